// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: reset PC default, fetch states, canonical NOP.
// Optional performance counters in ifu_fetch are enabled with the IFU_PERF_CNT_EN macro.
package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Two free-running 64-bit event counters for the fetch unit: accepted instructions and stall cycles.
// Only instantiated when IFU_PERF_CNT_EN is defined.
module ifu_perf_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        fire,
    input  logic        stall,
    output logic [63:0] fetch_cnt,
    output logic [63:0] stall_cnt
);

    // Both counters wrap silently at 2^64.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt <= 64'd0;
            stall_cnt <= 64'd0;
        end else begin
            if (fire) begin
                fetch_cnt <= fetch_cnt + 64'd1;
            end
            if (stall) begin
                stall_cnt <= stall_cnt + 64'd1;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch requester: one imem read per cycle, 1-cycle response tracking, redirect and backpressure.
// Define IFU_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_ren,
    output logic [XLEN-1:0] imem_raddr,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dbg_state
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);

    localparam logic ST_IDLE = logic'(IDLE);
    localparam logic ST_RESP = logic'(RESP);

    logic            state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [XLEN-1:0] issue_addr;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Handshake: out_valid/out_pc/out_inst transfer on a cycle where out_valid && out_ready; once raised,
    // out_valid holds with stable payload until that transfer, unless a redirect or reset kills it.
    assign issue_addr = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : fetch_pc_q;
    assign imem_ren   = !reset && (state_q == ST_IDLE || out_ready || redirect_valid);
    assign imem_raddr = reset ? RESET_PC : issue_addr;
    assign out_valid  = !reset && (state_q == ST_RESP) && !redirect_valid;
    assign out_pc     = resp_pc_q;
    assign out_inst   = imem_rdata;
    assign dbg_state  = state_q;

    // Without an issue the RAM keeps its rdata, so holding resp_pc keeps the presented pair stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
        end else if (imem_ren) begin
            state_q    <= ST_RESP;
            resp_pc_q  <= issue_addr;
            fetch_pc_q <= issue_addr + XLEN'(4);
        end
    end

`ifdef IFU_PERF_CNT_EN
    ifu_perf_cnt u_perf_cnt (
        .clock     (clock),
        .reset     (reset),
        .fire      (out_valid && out_ready),
        .stall     (out_valid && !out_ready),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
